// File: rtl/rom_burst_reader.sv
// rom_burst_reader: reads a burst of consecutive words from an asynchronous
// ROM and presents them one at a time on a valid/ready output register.
// Optional feature: define ROM_BURST_READER_CHECKSUM_EN to enable a running
// XOR checksum of the words of the current or last burst. Without it the
// checksum port is tied to zero.
module rom_burst_reader #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   burst_len,
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   remain;

   // Burst sequencer: rom_en/rom_addr are set on entry to FETCH so the ROM
   // sees the address for exactly the FETCH cycle; rom_addr doubles as the
   // current burst address and only moves when a new fetch is launched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rom_en    <= 1'b0;
         rom_addr  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         remain    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  remain <= burst_len;
                  if (burst_len != '0) begin
                     rom_addr <= start_addr;
                     rom_en   <= 1'b1;
                     state    <= FETCH;
                  end else begin
                     state <= FINISH;
                  end
               end
            end
            FETCH: begin
               out_data  <= rom_data;
               out_valid <= 1'b1;
               rom_en    <= 1'b0;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  remain    <= remain - 1'b1;
                  if (remain != (ADDR_WIDTH+1)'(1)) begin
                     // Natural ADDR_WIDTH overflow gives the modulo wrap.
                     rom_addr <= rom_addr + 1'b1;
                     rom_en   <= 1'b1;
                     state    <= FETCH;
                  end else begin
                     state <= FINISH;
                  end
               end
            end
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ROM_BURST_READER_CHECKSUM_EN
   // Running XOR: cleared by an accepted start, folds in each fetched word.
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum <= '0;
      end else if (state == IDLE && start) begin
         checksum <= '0;
      end else if (state == FETCH) begin
         checksum <= checksum ^ rom_data;
      end
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: directed burst scenarios plus
// randomized bursts against a queue-based model of the expected words.
module tb_rom_burst_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] start_addr;
   logic [4:0] burst_len;
   logic       rom_en;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic [7:0] checksum;

   logic [7:0] rom [16];

   int checks = 0;
   int errors = 0;

   // monitor state
   bit         mon_en = 1'b0;
   logic [7:0] beats [$];
   logic [3:0] addrs [$];
   int         dones = 0;
   int         stall_viol = 0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = '0;

   rom_burst_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .burst_len  (burst_len),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   assign rom_data = rom[rom_addr];

   // Observe between edges: inputs change just after posedge and stay put.
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid === 1'b1 && out_ready === 1'b1) beats.push_back(out_data);
         if (rom_en === 1'b1) addrs.push_back(rom_addr);
         if (done === 1'b1) dones++;
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || rom_en !== 1'b0))
            stall_viol++;
         prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
         prev_data  = out_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mon_clear();
      beats.delete();
      addrs.delete();
      dones      = 0;
      stall_viol = 0;
      prev_stall = 1'b0;
      mon_en     = 1'b1;
   endtask

   task automatic load_pattern();
      for (int i = 0; i < 16; i++) rom[i] = 8'(8'h11 * i);
   endtask

   // Drives one burst and checks timing landmarks, words, addresses,
   // done count, output stability and checksum against the model.
   task automatic run_burst(input logic [3:0] sa, input logic [4:0] len,
                            input int rdy_pct, input int stall_n,
                            input bit noisy, input string name);
      logic [7:0] exp_q [$];
      logic [3:0] exp_a [$];
      logic [7:0] exp_ck;
      logic [3:0] a;
      int         cyc;
      int         first_valid;
      int         done_cyc;
      exp_ck = '0;
      for (int i = 0; i < int'(len); i++) begin
         a = sa + 4'(i);
         exp_a.push_back(a);
         exp_q.push_back(rom[a]);
         exp_ck ^= rom[a];
      end
`ifndef ROM_BURST_READER_CHECKSUM_EN
      exp_ck = '0;
`endif
      mon_clear();
      start      = 1'b1;
      start_addr = sa;
      burst_len  = len;
      out_ready  = (stall_n > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || rom_en !== (len != 0)) begin
         errors++;
         $display("FAIL %s after-start busy/valid/rom_en got %b%b%b exp 1 0 %b",
                  name, busy, out_valid, rom_en, (len != 0));
      end
      cyc = 0;
      first_valid = -1;
      while (done !== 1'b1 && cyc < 400) begin
         out_ready = (cyc < stall_n) ? 1'b0 : ($urandom_range(99) < rdy_pct);
         if (noisy) begin
            start      = 1'($urandom_range(1));
            start_addr = 4'($urandom);
            burst_len  = 5'($urandom);
         end
         tick();
         cyc++;
         if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      end
      done_cyc  = cyc;
      start     = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (cyc >= 400) begin
         errors++;
         $display("FAIL %s timeout waiting for done after %0d cycles", name, cyc);
      end
      checks++;
      if (first_valid !== ((len != 0) ? 1 : -1)) begin
         errors++;
         $display("FAIL %s first out_valid cycle got %0d exp %0d",
                  name, first_valid, (len != 0) ? 1 : -1);
      end
      if (rdy_pct >= 100 && stall_n == 0) begin
         checks++;
         if (done_cyc !== 2 * int'(len) + 1) begin
            errors++;
            $display("FAIL %s done cycle got %0d exp %0d", name, done_cyc, 2 * int'(len) + 1);
         end
      end
      checks++;
      if (dones !== 1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s done pulses got %0d busy %b done %b exp 1 0 0", name, dones, busy, done);
      end
      checks++;
      if (beats.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL %s beat count got %0d exp %0d", name, beats.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (beats[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL %s beat%0d got %h exp %h", name, i, beats[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (addrs.size() !== exp_a.size()) begin
         errors++;
         $display("FAIL %s rom access count got %0d exp %0d", name, addrs.size(), exp_a.size());
      end else begin
         for (int i = 0; i < exp_a.size(); i++) begin
            checks++;
            if (addrs[i] !== exp_a[i]) begin
               errors++;
               $display("FAIL %s rom_addr%0d got %h exp %h", name, i, addrs[i], exp_a[i]);
            end
         end
      end
      checks++;
      if (stall_viol !== 0) begin
         errors++;
         $display("FAIL %s stall stability violations got %0d exp 0", name, stall_viol);
      end
      checks++;
      if (checksum !== exp_ck) begin
         errors++;
         $display("FAIL %s checksum got %h exp %h", name, checksum, exp_ck);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      burst_len  = '0;
      out_ready  = 1'b0;
      load_pattern();
      tick();
      tick();
      checks++;
      if ({rom_en, rom_addr, out_data, out_valid, busy, done, checksum} !== '0) begin
         errors++;
         $display("FAIL reset outputs got en%b addr%h data%h v%b busy%b done%b ck%h exp all 0",
                  rom_en, rom_addr, out_data, out_valid, busy, done, checksum);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      load_pattern();
      run_burst(4'd0, 5'd4, 100, 0, 1'b0, "basic");
   endtask

   task automatic test_wrap();
      run_burst(4'd14, 5'd4, 100, 0, 1'b0, "wrap");
   endtask

   task automatic test_stall();
      run_burst(4'd5, 5'd2, 100, 3, 1'b0, "stall");
   endtask

   task automatic test_zero_len();
      run_burst(4'd9, 5'd0, 100, 0, 1'b0, "zero_len");
   endtask

   task automatic test_ignore_start();
      run_burst(4'd0, 5'd16, 100, 0, 1'b1, "ignore_start");
   endtask

   task automatic test_reset_mid();
      int cyc;
      mon_clear();
      start      = 1'b1;
      start_addr = 4'd0;
      burst_len  = 5'd8;
      out_ready  = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (beats.size() < 2 && cyc < 50) begin
         tick();
         cyc++;
      end
      checks++;
      if (beats.size() !== 2) begin
         errors++;
         $display("FAIL reset_mid beats before reset got %0d exp 2", beats.size());
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({rom_en, rom_addr, out_data, out_valid, busy, done, checksum} !== '0) begin
         errors++;
         $display("FAIL reset_mid outputs got en%b addr%h data%h v%b busy%b done%b ck%h exp all 0",
                  rom_en, rom_addr, out_data, out_valid, busy, done, checksum);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (dones !== 0 || out_valid !== 1'b0 || busy !== 1'b0 || beats.size() !== 2) begin
         errors++;
         $display("FAIL reset_mid aftermath got dones %0d valid %b busy %b beats %0d exp 0 0 0 2",
                  dones, out_valid, busy, beats.size());
      end
      run_burst(4'd3, 5'd3, 100, 0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      for (int n = 0; n < 12; n++) begin
         run_burst(4'($urandom), 5'($urandom_range(16)), $urandom_range(30, 100),
                   $urandom_range(0, 3), 1'($urandom_range(1)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_zero_len();
      test_ignore_start();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_burst_reader.md
ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, the ROM address width (16 locations).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, the ROM data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, a single-cycle request to begin a burst, sampled only in IDLE.
REQ-006 The block SHALL have port start_addr, input, ADDR_WIDTH, the first ROM address of the burst.
REQ-007 The block SHALL have port burst_len, input, ADDR_WIDTH+1, the number of words to read (0..16).
REQ-008 The block SHALL have port rom_en, output, 1, the enable driven to the asynchronous ROM.
REQ-009 The block SHALL have port rom_addr, output, ADDR_WIDTH, the address driven to the ROM.
REQ-010 The block SHALL have port rom_data, input, DATA_WIDTH, the combinational ROM read data.
REQ-011 The block SHALL have port out_data, output, DATA_WIDTH, the registered word presented downstream.
REQ-012 The block SHALL have port out_valid, output, 1, asserted when out_data holds an unconsumed word.
REQ-013 The block SHALL have port out_ready, input, 1, the downstream accept; a beat transfers when out_valid and out_ready are both 1 at a rising edge.
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 The block SHALL have port done, output, 1, a one-cycle pulse at the end of each burst.
REQ-016 The block SHALL have port checksum, output, DATA_WIDTH, the XOR of all words of the current or last burst.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, HOLD and FINISH.
REQ-018 In IDLE with start=1 and burst_len>0, the block SHALL latch start_addr and burst_len and go to FETCH on the next edge.
REQ-019 In IDLE with start=1 and burst_len=0, the block SHALL go to FINISH without any ROM access or output beat.
REQ-020 In FETCH, rom_en SHALL be 1 and rom_addr SHALL equal the current address for exactly one cycle.
REQ-021 At the end of FETCH, rom_data SHALL be registered into out_data, out_valid SHALL be set, and the state SHALL go to HOLD.
REQ-022 In all states other than FETCH, rom_en SHALL be 0 and rom_addr SHALL hold its last value.
REQ-023 In HOLD, out_data and out_valid SHALL stay stable until out_ready=1.
REQ-024 On the HOLD handshake, out_valid SHALL clear, the remaining count SHALL decrement, and the address SHALL increment modulo 16, so 15 wraps to 0.
REQ-025 After the HOLD handshake, the state SHALL return to FETCH if the count is still nonzero, otherwise go to FINISH.
REQ-026 With out_ready held high, the block SHALL sustain one word per two cycles, and the first out_valid SHALL appear two cycles after the start edge.
REQ-027 FINISH SHALL assert done for one cycle and then return to IDLE.
REQ-028 start SHALL be ignored while busy=1, and the latched parameters SHALL NOT change mid-burst.
REQ-029 Changes on start_addr or burst_len outside the IDLE start edge SHALL have no effect.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL enter IDLE and drive rom_en=0, rom_addr=0, out_data=0, out_valid=0, busy=0, done=0 and checksum=0.
REQ-031 A reset asserted mid-burst SHALL abort the burst immediately, with no done pulse and any pending beat discarded.

Configuration
REQ-032 With macro ROM_BURST_READER_CHECKSUM_EN defined, checksum SHALL clear on each accepted start and XOR in each word as it is registered in FETCH.
REQ-033 Without ROM_BURST_READER_CHECKSUM_EN, the checksum port SHALL remain present and be driven constant 0.

Verification
REQ-034 Reset, then start with start_addr=0, burst_len=4, out_ready=1 and the ROM pattern mem[i]=0x11*i -> beats 0x00,0x11,0x22,0x33; one done pulse; checksum=0x00 (macro on).
REQ-035 start_addr=14, burst_len=4 -> beats 0xEE,0xFF,0x00,0x11 with rom_addr wrapping 15->0.
REQ-036 start_addr=5, burst_len=2, out_ready low for 3 cycles on the first beat -> out_data holds 0x55 stable with out_valid=1, rom_en stays 0, then 0x66 follows.
REQ-037 burst_len=0 -> done pulses 2 cycles after start, rom_en never asserts, out_valid never asserts.
REQ-038 start pulses during a 16-word burst from address 0 -> ignored; exactly 16 beats 0x00..0xFF; checksum=0x00.
REQ-039 rst asserted after the 2nd beat of an 8-word burst -> next cycle all outputs 0 and IDLE, no done; a new start works normally.
